// File: rtl/nubus_pkg.sv
// Shared types for the NuBus slave engine: ACK status codes, transfer modes,
// FSM states and the byte-lane mask lookup.
package nubus_pkg;

    // ACK status as {tm1_o_n, tm0_o_n}
    localparam logic [1:0] TMN_COMPLETE        = 2'b00;
    localparam logic [1:0] TMN_ERROR           = 2'b01;
    localparam logic [1:0] TMN_TRY_AGAIN_LATER = 2'b11;

    typedef enum logic [2:0] {
        XFER_WORD,
        XFER_HALF0,
        XFER_HALF1,
        XFER_BYTE0,
        XFER_BYTE1,
        XFER_BYTE2,
        XFER_BYTE3,
        XFER_BLOCK
    } xfer_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CAPT,
        ST_MEM,
        ST_ACK
    } state_e;

    function automatic logic [3:0] lane_mask(input xfer_mode_e mode);
        logic [3:0] be;
        be = 4'b0000;
        case (mode)
            XFER_WORD:  be = 4'b1111;
            XFER_HALF0: be = 4'b0011;
            XFER_HALF1: be = 4'b1100;
            XFER_BYTE0: be = 4'b0001;
            XFER_BYTE1: be = 4'b0010;
            XFER_BYTE2: be = 4'b0100;
            XFER_BYTE3: be = 4'b1000;
            default:    be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/nubus_slave_ctrl_if.sv
// Pin-level bundle of the NuBus slave engine: NuBus side (active low) and
// local memory request side. slave = engine view, master = environment view.
interface nubus_slave_ctrl_if;
    logic [3:0]  id_n;
    logic        start_n;
    logic        ack_n;
    logic        tm0_n;
    logic        tm1_n;
    logic [31:0] ad_n;
    logic [31:0] ad_o_n;
    logic        ad_oe;
    logic        tm0_o_n;
    logic        tm1_o_n;
    logic        tm_oe;
    logic        ack_o_n;
    logic        ack_oe;
    logic        busy;
    logic        mem_valid;
    logic        mem_we;
    logic [25:0] mem_addr;
    logic        mem_space;
    logic [3:0]  mem_be;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_err;
    logic [31:0] mem_rdata;
    logic        mem_abort;

    modport slave (
        input  id_n, start_n, ack_n, tm0_n, tm1_n, ad_n,
        input  mem_ready, mem_err, mem_rdata,
        output ad_o_n, ad_oe, tm0_o_n, tm1_o_n, tm_oe, ack_o_n, ack_oe, busy,
        output mem_valid, mem_we, mem_addr, mem_space, mem_be, mem_wdata, mem_abort
    );

    modport master (
        output id_n, start_n, ack_n, tm0_n, tm1_n, ad_n,
        output mem_ready, mem_err, mem_rdata,
        input  ad_o_n, ad_oe, tm0_o_n, tm1_o_n, tm_oe, ack_o_n, ack_oe, busy,
        input  mem_valid, mem_we, mem_addr, mem_space, mem_be, mem_wdata, mem_abort
    );
endinterface

// File: rtl/nubus_tm_decode.sv
// Combinational decode of NuBus transfer mode and address low bits into
// write flag, byte enables and block flag.
module nubus_tm_decode
    import nubus_pkg::*;
(
    input  logic       tm1_n,
    input  logic       tm0_n,
    input  logic [1:0] ad_lo_n,
    output logic       we,
    output logic [3:0] be,
    output logic       block
);

    xfer_mode_e mode;

    always_comb begin
        mode = XFER_BLOCK;
        case ({tm0_n, ad_lo_n})
            3'b111:  mode = XFER_WORD;
            3'b101:  mode = XFER_HALF0;
            3'b001:  mode = XFER_HALF1;
            3'b110:  mode = XFER_BYTE0;
            3'b100:  mode = XFER_BYTE1;
            3'b010:  mode = XFER_BYTE2;
            3'b000:  mode = XFER_BYTE3;
            default: mode = XFER_BLOCK;
        endcase
    end

    assign we    = ~tm1_n;
    assign be    = lane_mask(mode);
    assign block = (mode == XFER_BLOCK);

endmodule

// File: rtl/nubus_slave_ctrl.sv
// NuBus slave protocol engine: slot decode, one local request per transaction,
// ACK with status/read data. Define SUPERSLOT_EN to also decode super slot space.
//
// state | meaning
// IDLE  | waiting for a start cycle addressed to this slot
// CAPT  | address phase done; write data latched at end of cycle
// MEM   | local request outstanding, timeout counter running
// ACK   | one-cycle ACK drive with status (and read data)
module nubus_slave_ctrl
    import nubus_pkg::*;
#(
    parameter int TAL_CYCLES = 96
) (
    input  logic              nubus_clk,
    input  logic              nubus_rst,
    nubus_slave_ctrl_if.slave bus
);

    localparam logic [7:0] TAL_LOAD = 8'(TAL_CYCLES - 1);

    state_e      state_q, state_d;
    logic [25:0] addr_q, addr_d;
    logic        space_q, space_d;
    logic [3:0]  be_q, be_d;
    logic        we_q, we_d;
    logic        block_q, block_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  status_q, status_d;
    logic [31:0] rdata_n_q, rdata_n_d;

    logic [3:0]  slot;
    logic [31:0] addr;
    logic        hit_std, hit_super, start_ok, abort;
    logic        dec_we, dec_block;
    logic [3:0]  dec_be;
    logic [31:0] be_bits;

    nubus_tm_decode u_tm_decode (
        .tm1_n   (bus.tm1_n),
        .tm0_n   (bus.tm0_n),
        .ad_lo_n (bus.ad_n[1:0]),
        .we      (dec_we),
        .be      (dec_be),
        .block   (dec_block)
    );

    assign slot    = ~bus.id_n;
    assign addr    = ~bus.ad_n;
    assign hit_std = (addr[31:24] == {4'hF, slot});
`ifdef SUPERSLOT_EN
    assign hit_super = (addr[31:28] == slot) && (slot != 4'h0) && (slot != 4'hF);
`else
    assign hit_super = 1'b0;
`endif
    // An attention cycle (start with ack asserted) is never a transaction
    assign start_ok = !bus.start_n && bus.ack_n && (hit_std || hit_super);
    assign be_bits  = {{8{be_q[3]}}, {8{be_q[2]}}, {8{be_q[1]}}, {8{be_q[0]}}};

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        space_d   = space_q;
        be_d      = be_q;
        we_d      = we_q;
        block_d   = block_q;
        wdata_d   = wdata_q;
        cnt_d     = cnt_q;
        status_d  = status_q;
        rdata_n_d = rdata_n_q;
        abort     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start_ok) begin
                    state_d = ST_CAPT;
                    addr_d  = hit_super ? addr[27:2] : {4'b0000, addr[23:2]};
                    space_d = hit_super;
                    be_d    = dec_be;
                    we_d    = dec_we;
                    block_d = dec_block;
                end
            end
            ST_CAPT: begin
                if (we_q) wdata_d = addr;
                if (block_q) begin
                    state_d   = ST_ACK;
                    status_d  = TMN_ERROR;
                    rdata_n_d = '1;
                end else begin
                    state_d = ST_MEM;
                    cnt_d   = TAL_LOAD;
                end
            end
            ST_MEM: begin
                // mem_ready on the terminal cycle still completes normally
                if (bus.mem_ready) begin
                    state_d   = ST_ACK;
                    status_d  = bus.mem_err ? TMN_ERROR : TMN_COMPLETE;
                    rdata_n_d = ~(bus.mem_rdata & be_bits);
                end else if (cnt_q == 8'd0) begin
                    state_d   = ST_ACK;
                    status_d  = TMN_TRY_AGAIN_LATER;
                    rdata_n_d = '1;
                    abort     = 1'b1;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ACK: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge nubus_clk or posedge nubus_rst) begin
        if (nubus_rst) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            space_q   <= 1'b0;
            be_q      <= '0;
            we_q      <= 1'b0;
            block_q   <= 1'b0;
            wdata_q   <= '0;
            cnt_q     <= '0;
            status_q  <= 2'b11;
            rdata_n_q <= '1;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            space_q   <= space_d;
            be_q      <= be_d;
            we_q      <= we_d;
            block_q   <= block_d;
            wdata_q   <= wdata_d;
            cnt_q     <= cnt_d;
            status_q  <= status_d;
            rdata_n_q <= rdata_n_d;
        end
    end

    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.mem_valid = (state_q == ST_MEM);
    assign bus.mem_abort = abort;
    assign bus.mem_we    = we_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_space = space_q;
    assign bus.mem_be    = be_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.ack_oe    = (state_q == ST_ACK);
    assign bus.tm_oe     = (state_q == ST_ACK);
    assign bus.ad_oe     = (state_q == ST_ACK) && !we_q;
    assign bus.ack_o_n   = (state_q != ST_ACK);
    assign bus.tm1_o_n   = status_q[1];
    assign bus.tm0_o_n   = status_q[0];
    assign bus.ad_o_n    = rdata_n_q;

endmodule

// File: tb/tb_nubus_slave_ctrl.sv
// Directed bench for nubus_slave_ctrl: vector table of single transactions
// plus hand sequences for timeout, ready-vs-timeout, busy start and reset.
module tb_nubus_slave_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks   = 0;
    int   failures = 0;

    nubus_slave_ctrl_if bus_if ();

    nubus_slave_ctrl #(.TAL_CYCLES(96)) dut (
        .nubus_clk (clk),
        .nubus_rst (rst),
        .bus       (bus_if)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        write;
        logic        tm0_n;
        logic [1:0]  lane_n;
        logic        ack_n;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        int          delay;
        logic        exp_accept;
        logic        exp_block;
        logic [3:0]  exp_be;
        logic [25:0] exp_maddr;
        logic        exp_space;
        logic [1:0]  exp_status;
        logic [31:0] exp_ad;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic bus_idle();
        bus_if.start_n   = 1'b1;
        bus_if.ack_n     = 1'b1;
        bus_if.tm0_n     = 1'b1;
        bus_if.tm1_n     = 1'b1;
        bus_if.ad_n      = '1;
        bus_if.mem_ready = 1'b0;
        bus_if.mem_err   = 1'b0;
        bus_if.mem_rdata = 32'h0;
    endtask

    task automatic drive_start(input logic write, input logic tm0_n, input logic [1:0] lane_n,
                               input logic ack_n, input logic [31:0] addr);
        bus_if.start_n = 1'b0;
        bus_if.ack_n   = ack_n;
        bus_if.tm1_n   = ~write;
        bus_if.tm0_n   = tm0_n;
        bus_if.ad_n    = {~addr[31:2], lane_n};
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        string tag;
        tag = $sformatf("v%0d", idx);
        @(negedge clk);
        drive_start(v.write, v.tm0_n, v.lane_n, v.ack_n, v.addr);
        @(negedge clk);
        bus_if.start_n = 1'b1;
        bus_if.ack_n   = 1'b1;
        bus_if.ad_n    = ~v.wdata;
        if (!v.exp_accept) begin
            for (int i = 0; i < 3; i++) begin
                check({tag, "_ignored_busy"}, 32'(bus_if.busy), 32'd0);
                check({tag, "_ignored_valid"}, 32'(bus_if.mem_valid), 32'd0);
                @(negedge clk);
            end
            return;
        end
        check({tag, "_capt_busy"}, 32'(bus_if.busy), 32'd1);
        @(negedge clk);
        if (v.exp_block) begin
            check({tag, "_blk_valid"}, 32'(bus_if.mem_valid), 32'd0);
            check({tag, "_blk_ack_oe"}, 32'(bus_if.ack_oe), 32'd1);
            check({tag, "_blk_status"}, 32'({bus_if.tm1_o_n, bus_if.tm0_o_n}), 32'(v.exp_status));
        end else begin
            check({tag, "_valid"}, 32'(bus_if.mem_valid), 32'd1);
            check({tag, "_addr"}, 32'(bus_if.mem_addr), 32'(v.exp_maddr));
            check({tag, "_space"}, 32'(bus_if.mem_space), 32'(v.exp_space));
            check({tag, "_be"}, 32'(bus_if.mem_be), 32'(v.exp_be));
            check({tag, "_we"}, 32'(bus_if.mem_we), 32'(v.write));
            if (v.write) check({tag, "_wdata"}, bus_if.mem_wdata, v.wdata);
            bus_if.ad_n = '1;
            repeat (v.delay) @(negedge clk);
            check({tag, "_valid_held"}, 32'(bus_if.mem_valid), 32'd1);
            bus_if.mem_ready = 1'b1;
            bus_if.mem_err   = v.err;
            bus_if.mem_rdata = v.rdata;
            @(negedge clk);
            bus_if.mem_ready = 1'b0;
            bus_if.mem_err   = 1'b0;
            bus_if.mem_rdata = 32'h0F0F0F0F;
            check({tag, "_ack_valid"}, 32'(bus_if.mem_valid), 32'd0);
            check({tag, "_ack_oe"}, 32'(bus_if.ack_oe), 32'd1);
            check({tag, "_ack_o_n"}, 32'(bus_if.ack_o_n), 32'd0);
            check({tag, "_tm_oe"}, 32'(bus_if.tm_oe), 32'd1);
            check({tag, "_status"}, 32'({bus_if.tm1_o_n, bus_if.tm0_o_n}), 32'(v.exp_status));
            check({tag, "_ad_oe"}, 32'(bus_if.ad_oe), 32'(!v.write));
            if (!v.write) check({tag, "_ad_o_n"}, bus_if.ad_o_n, v.exp_ad);
        end
        @(negedge clk);
        check({tag, "_end_ack_oe"}, 32'(bus_if.ack_oe), 32'd0);
        check({tag, "_end_busy"}, 32'(bus_if.busy), 32'd0);
    endtask

    initial begin
        int  valid_cnt;
        int  abort_cnt;
        logic got_ack;
        logic stray;

        // Fields: write tm0_n lane_n ack_n addr wdata rdata err delay
        //         accept block be maddr space status ad_o_n
        vecs[0]  = '{1'b1, 1'b1, 2'b11, 1'b1, 32'hFC000000, 32'h87654321, 32'h0, 1'b0, 0,
                     1'b1, 1'b0, 4'b1111, 26'h0, 1'b0, 2'b00, 32'hFFFFFFFF};
        vecs[1]  = '{1'b0, 1'b0, 2'b01, 1'b1, 32'hFC000008, 32'h0, 32'h87654321, 1'b0, 0,
                     1'b1, 1'b0, 4'b1100, 26'h2, 1'b0, 2'b00, 32'h789AFFFF};
        vecs[2]  = '{1'b1, 1'b0, 2'b10, 1'b1, 32'hFC000014, 32'h00AB0000, 32'h0, 1'b0, 2,
                     1'b1, 1'b0, 4'b0100, 26'h5, 1'b0, 2'b00, 32'hFFFFFFFF};
        vecs[3]  = '{1'b0, 1'b0, 2'b11, 1'b1, 32'hFC000020, 32'h0, 32'h0, 1'b0, 0,
                     1'b1, 1'b1, 4'b0000, 26'h0, 1'b0, 2'b01, 32'hFFFFFFFF};
        vecs[4]  = '{1'b0, 1'b1, 2'b11, 1'b1, 32'hFB000000, 32'h0, 32'h0, 1'b0, 0,
                     1'b0, 1'b0, 4'b0000, 26'h0, 1'b0, 2'b00, 32'hFFFFFFFF};
        vecs[5]  = '{1'b0, 1'b1, 2'b10, 1'b1, 32'hFC000100, 32'h0, 32'hDEADBEEF, 1'b1, 1,
                     1'b1, 1'b0, 4'b0001, 26'h40, 1'b0, 2'b01, 32'hFFFFFF10};
        vecs[6]  = '{1'b0, 1'b1, 2'b11, 1'b0, 32'hFC000000, 32'h0, 32'h0, 1'b0, 0,
                     1'b0, 1'b0, 4'b0000, 26'h0, 1'b0, 2'b00, 32'hFFFFFFFF};
        vecs[7]  = '{1'b0, 1'b0, 2'b00, 1'b1, 32'hFC3FFFFC, 32'h0, 32'h12345678, 1'b0, 1,
                     1'b1, 1'b0, 4'b1000, 26'hFFFFF, 1'b0, 2'b00, 32'hEDFFFFFF};
        vecs[8]  = '{1'b1, 1'b1, 2'b01, 1'b1, 32'hFC000040, 32'h0000BEEF, 32'h0, 1'b0, 0,
                     1'b1, 1'b0, 4'b0011, 26'h10, 1'b0, 2'b00, 32'hFFFFFFFF};
        vecs[9]  = '{1'b0, 1'b1, 2'b00, 1'b1, 32'hFC000044, 32'h0, 32'hA1B2C3D4, 1'b0, 0,
                     1'b1, 1'b0, 4'b0010, 26'h11, 1'b0, 2'b00, 32'hFFFF3CFF};
        vecs[10] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'hFD000000, 32'h0, 32'h0, 1'b0, 0,
                     1'b0, 1'b0, 4'b0000, 26'h0, 1'b0, 2'b00, 32'hFFFFFFFF};
`ifdef SUPERSLOT_EN
        vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'hC0000104, 32'h0, 32'h55AA55AA, 1'b0, 0,
                     1'b1, 1'b0, 4'b1111, 26'h41, 1'b1, 2'b00, 32'hAA55AA55};
`else
        vecs[11] = '{1'b0, 1'b1, 2'b11, 1'b1, 32'hC0000104, 32'h0, 32'h55AA55AA, 1'b0, 0,
                     1'b0, 1'b0, 4'b0000, 26'h0, 1'b0, 2'b00, 32'hFFFFFFFF};
`endif

        bus_if.id_n = ~4'hC;
        bus_idle();
        repeat (2) @(negedge clk);
        check("rst_ad_oe", 32'(bus_if.ad_oe), 32'd0);
        check("rst_tm_oe", 32'(bus_if.tm_oe), 32'd0);
        check("rst_ack_oe", 32'(bus_if.ack_oe), 32'd0);
        check("rst_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        check("rst_mem_we", 32'(bus_if.mem_we), 32'd0);
        check("rst_mem_abort", 32'(bus_if.mem_abort), 32'd0);
        check("rst_busy", 32'(bus_if.busy), 32'd0);
        check("rst_ad_o_n", bus_if.ad_o_n, 32'hFFFFFFFF);
        check("rst_tm_o_n", 32'({bus_if.tm1_o_n, bus_if.tm0_o_n}), 32'd3);
        check("rst_ack_o_n", 32'(bus_if.ack_o_n), 32'd1);
        check("rst_mem_addr", 32'(bus_if.mem_addr), 32'd0);
        check("rst_mem_be", 32'(bus_if.mem_be), 32'd0);
        check("rst_mem_wdata", bus_if.mem_wdata, 32'd0);
        check("rst_mem_space", 32'(bus_if.mem_space), 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 12; i++) run_vec(i, vecs[i]);

        // Timeout: mem_ready never arrives
        @(negedge clk);
        drive_start(1'b0, 1'b1, 2'b11, 1'b1, 32'hFC000200);
        @(negedge clk);
        bus_idle();
        valid_cnt = 0;
        abort_cnt = 0;
        got_ack   = 1'b0;
        for (int i = 0; i < 200 && !got_ack; i++) begin
            @(negedge clk);
            if (bus_if.ack_oe) begin
                got_ack = 1'b1;
                check("tal_status", 32'({bus_if.tm1_o_n, bus_if.tm0_o_n}), 32'd3);
                check("tal_abort_in_ack", 32'(bus_if.mem_abort), 32'd0);
            end else begin
                valid_cnt += int'(bus_if.mem_valid);
                abort_cnt += int'(bus_if.mem_abort);
            end
        end
        check("tal_ack_seen", 32'(got_ack), 32'd1);
        check("tal_valid_cycles", 32'(valid_cnt), 32'd96);
        check("tal_abort_pulses", 32'(abort_cnt), 32'd1);
        @(negedge clk);
        check("tal_end_busy", 32'(bus_if.busy), 32'd0);

        // mem_ready on the terminal cycle wins; a start during MEM is ignored
        drive_start(1'b0, 1'b1, 2'b11, 1'b1, 32'hFC000200);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        repeat (4) @(negedge clk);
        drive_start(1'b1, 1'b1, 2'b11, 1'b1, 32'hFC000400);
        @(negedge clk);
        bus_idle();
        check("busy_start_addr", 32'(bus_if.mem_addr), 32'h80);
        check("busy_start_we", 32'(bus_if.mem_we), 32'd0);
        repeat (90) @(negedge clk);
        check("race_still_valid", 32'(bus_if.mem_valid), 32'd1);
        bus_if.mem_ready = 1'b1;
        bus_if.mem_rdata = 32'h13579BDF;
        #1;
        check("race_abort_suppressed", 32'(bus_if.mem_abort), 32'd0);
        @(negedge clk);
        bus_idle();
        check("race_ack_oe", 32'(bus_if.ack_oe), 32'd1);
        check("race_status", 32'({bus_if.tm1_o_n, bus_if.tm0_o_n}), 32'd0);
        check("race_ad_o_n", bus_if.ad_o_n, 32'hECA86420);
        @(negedge clk);
        check("race_end_busy", 32'(bus_if.busy), 32'd0);
        @(negedge clk);
        check("busy_start_no_txn", 32'(bus_if.busy), 32'd0);

        // Reset while in MEM
        drive_start(1'b1, 1'b1, 2'b11, 1'b1, 32'hFC000000);
        @(negedge clk);
        bus_if.start_n = 1'b1;
        bus_if.ad_n    = ~32'h11223344;
        @(negedge clk);
        bus_idle();
        check("rstmem_pre_valid", 32'(bus_if.mem_valid), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstmem_ack_oe", 32'(bus_if.ack_oe), 32'd0);
        check("rstmem_mem_valid", 32'(bus_if.mem_valid), 32'd0);
        check("rstmem_busy", 32'(bus_if.busy), 32'd0);
        check("rstmem_mem_be", 32'(bus_if.mem_be), 32'd0);
        @(negedge clk);
        rst   = 1'b0;
        stray = 1'b0;
        repeat (4) begin
            @(negedge clk);
            stray = stray | bus_if.ack_oe | bus_if.busy | bus_if.mem_valid;
        end
        check("rstmem_no_ack_after", 32'(stray), 32'd0);

        // Reset while driving ACK drops all enables without waiting for a clock
        drive_start(1'b0, 1'b0, 2'b11, 1'b1, 32'hFC000020);
        @(negedge clk);
        bus_idle();
        @(negedge clk);
        check("rstack_pre_ack_oe", 32'(bus_if.ack_oe), 32'd1);
        #1 rst = 1'b1;
        #1;
        check("rstack_ack_oe", 32'(bus_if.ack_oe), 32'd0);
        check("rstack_tm_oe", 32'(bus_if.tm_oe), 32'd0);
        check("rstack_ad_oe", 32'(bus_if.ad_oe), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nubus_slave_ctrl.md
# nubus_slave_ctrl

NuBus slave protocol engine between the level-shifted NuBus pins (CPLD and '245 transceivers) and the card's local memory/register fabric. It recognises start cycles addressed to this slot, decodes transfer mode and byte lanes, issues one local-bus request per transaction, and terminates the NuBus cycle with an ACK carrying status and, for reads, data. It is the stage directly upstream of the memory, ROM and ping-master register decoders.

## Interface
- TAL_CYCLES, 96: local wait cycles before answering Try-Again-Later; legal range 1..200, below the 255-cycle motherboard bus timeout.
- nubus_clk  in  1  NuBus clock, the inverse of clk_3v3_n; rising edge is the NuBus sampling edge.
- nubus_rst  in  1  asynchronous, active-high reset.
- id_n  in  4  slot ID, active low.
- start_n, ack_n, tm0_n, tm1_n  in  1  NuBus control inputs, active low.
- ad_n  in  32  NuBus AD inputs, active low.
- ad_o_n  out  32  AD drive value; ad_oe  out  1  AD drive enable.
- tm0_o_n, tm1_o_n  out  1  status drive values; tm_oe  out  1  TM drive enable.
- ack_o_n  out  1  ACK drive value; ack_oe  out  1  ACK drive enable.
- busy  out  1  high from the accepted start cycle to the end of the ACK cycle.
- mem_valid, mem_we  out  1  local request and write flag.
- mem_addr  out  26  word address (byte address bits 27:2).
- mem_space  out  1  0 = standard slot space, 1 = super slot space.
- mem_be  out  4  byte enables; bit n covers AD[8n+7:8n].
- mem_wdata  out  32  write data, true polarity.
- mem_ready, mem_err  in  1  completion and error, sampled with mem_valid.
- mem_rdata  in  32  read data, valid with mem_ready.
- mem_abort  out  1  one-cycle pulse when a request is withdrawn on timeout.

## Operation
- Invert all bus inputs internally. slot = ~id_n. addr = ~ad_n.
- Accept a start cycle when start_n=0 and ack_n=1 on a nubus_clk edge, and addr[31:24] = {4'hF, slot}. Start with ack_n=0 is an attention cycle and is ignored.
- Transfer mode: write when tm1_n=0, read when tm1_n=1. The lane is given by {tm0_n, ad_n[1:0]}:
  - 111 word, be 1111.
  - 101 half 0, be 0011. 001 half 1, be 1100.
  - 110 byte 0, be 0001. 100 byte 1, be 0010. 010 byte 2, be 0100. 000 byte 3, be 1000.
  - 011 block. No local request is issued; the block answers Error.
- States:
  - IDLE: waiting for an accepted start cycle.
  - CAPT: one cycle; for writes, latch ~ad_n into mem_wdata at the end of the cycle.
  - MEM: mem_valid=1 with stable address, be, we and wdata. Leave on mem_ready or on the timeout counter reaching TAL_CYCLES.
  - ACK: one cycle, then IDLE.
- Status in ACK, as {tm1_o_n, tm0_o_n}:
  - Complete = 00, when mem_ready=1 and mem_err=0.
  - Error = 01, when mem_err=1 or the transfer is a block.
  - Try-Again-Later = 11, on timeout; mem_abort pulses for the cycle that leaves MEM.
- Read ACK: ad_o_n = ~(mem_rdata masked by be), so unselected lanes read as 0. The data is registered at the mem_ready sample.
- Write ACK: ad_oe stays 0.

## Timing
- Reset values: ad_oe, tm_oe, ack_oe, mem_valid, mem_we and mem_abort are 0. ad_o_n, tm0_o_n, tm1_o_n and ack_o_n are all-ones. mem_addr, mem_be, mem_wdata and mem_space are 0. busy is 0. FSM is in IDLE.
- Reset mid-transaction: all drive enables fall immediately (asynchronously). No ACK is issued for the interrupted transaction.
- Start sampled at edge T0. CAPT covers T0–T1. mem_valid rises at T1.
- mem_ready sampled at edge Tn (Tn ≥ T2): ACK drives from Tn to Tn+1, mem_valid falls at Tn, and the master samples ACK at Tn+1.
- Minimum start-to-ACK-sample latency is 3 clocks.
- Timeout counter:
  - Counts MEM cycles and resets on entry to MEM.
  - Reaching TAL_CYCLES forces ACK. Simultaneous mem_ready wins over the timeout.
  - Block transfers go CAPT → ACK directly.
- Start cycles arriving outside IDLE are ignored.
- ack_oe, tm_oe and ad_oe (reads) are asserted together for exactly one cycle.

## Configuration
- SUPERSLOT_EN defined:
  - Also accept addr[31:28] = slot with slot ≠ 0 and slot ≠ 4'hF.
  - mem_space=1 and mem_addr = addr[27:2].
- Not defined: only standard slot space is decoded; mem_space is tied to 0; mem_addr[25:22] = 0.

## Structure
- Package nubus_pkg:
  - Status constants (TMN_COMPLETE, TMN_ERROR, TMN_TRY_AGAIN_LATER).
  - Transfer-mode enum.
  - FSM state enum.
  - Lane-mask function.
- Sub-module nubus_tm_decode: combinational mapping of {tm1_n, tm0_n, ad_n[1:0]} to write flag, be and block flag.

## Test plan
- Card ID 4'hC, write word 0xFC000000 with 0x87654321, mem_ready one cycle after mem_valid → mem_be=1111, mem_wdata=0x87654321, ACK status 00 at T3.
- Read half 1 at 0xFC000008, mem_rdata=0x87654321 → ad_o_n = ~0x87650000, status 00.
- Write byte 2 at 0xFC000014 → mem_be=0100.
- Block read → no mem_valid, status 01.
- Read at 0xFB000000 → ignored, busy stays 0.
- mem_ready held low → status 11 after 96 MEM cycles, mem_abort pulses once.
- nubus_rst asserted while in MEM → ack_oe, mem_valid and busy all 0 in the same cycle.
